// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port round-robin arbiter sharing one single-port SRAM.
// Each port has one outstanding access; a stalled response is parked in a per-port hold register.
module sram_arbiter #(
    parameter int LEN_ADDR = 32,
    parameter int LEN_DATA = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [LEN_ADDR-1:0]   req0_addr,
    input  logic [LEN_DATA-1:0]   req0_wdata,
    input  logic [LEN_DATA/8-1:0] req0_wstrb,
    output logic                  resp0_valid,
    input  logic                  resp0_ready,
    output logic [LEN_DATA-1:0]   resp0_rdata,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [LEN_ADDR-1:0]   req1_addr,
    input  logic [LEN_DATA-1:0]   req1_wdata,
    input  logic [LEN_DATA/8-1:0] req1_wstrb,
    output logic                  resp1_valid,
    input  logic                  resp1_ready,
    output logic [LEN_DATA-1:0]   resp1_rdata,
    output logic [LEN_ADDR-1:0]   sram_addr,
    output logic [LEN_DATA-1:0]   sram_din,
    output logic                  sram_en,
    output logic [LEN_DATA/8-1:0] sram_we,
    input  logic [LEN_DATA-1:0]   sram_dout
);
    logic                r_inflight0, r_inflight1, r_held0, r_held1, r_last_grant;
    logic [LEN_DATA-1:0] r_hold0, r_hold1;
    logic                w_elig0, w_elig1, w_cand0, w_cand1, w_grant1, w_acc0, w_acc1;

    always_comb begin
        w_elig0     = !(r_inflight0 | r_held0) | resp0_ready;
        w_elig1     = !(r_inflight1 | r_held1) | resp1_ready;
        w_cand0     = req0_valid & w_elig0;
        w_cand1     = req1_valid & w_elig1;
        // tie or no candidate: the port not granted last gets the slot
        w_grant1    = (w_cand0 == w_cand1) ? !r_last_grant : w_cand1;
        req0_ready  = !rst & w_elig0 & !w_grant1;
        req1_ready  = !rst & w_elig1 & w_grant1;
        w_acc0      = req0_valid & req0_ready;
        w_acc1      = req1_valid & req1_ready;
        sram_en     = w_acc0 | w_acc1;
        sram_addr   = w_acc1 ? req1_addr : req0_addr;
        sram_din    = w_acc1 ? req1_wdata : req0_wdata;
        sram_we     = w_acc1 ? req1_wstrb : w_acc0 ? req0_wstrb : '0;
        resp0_valid = !rst & (r_inflight0 | r_held0);
        resp1_valid = !rst & (r_inflight1 | r_held1);
        resp0_rdata = r_inflight0 ? sram_dout : r_hold0;
        resp1_rdata = r_inflight1 ? sram_dout : r_hold1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight0  <= 1'b0;
            r_inflight1  <= 1'b0;
            r_held0      <= 1'b0;
            r_held1      <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_inflight0 <= w_acc0;
            r_inflight1 <= w_acc1;
            r_held0     <= (r_inflight0 | r_held0) & !resp0_ready;
            r_held1     <= (r_inflight1 | r_held1) & !resp1_ready;
            if (sram_en) r_last_grant <= w_acc1;
        end
    end

    // sram_dout lasts one cycle only, so an unconsumed response is captured here
    always_ff @(posedge clk) begin
        if (r_inflight0 & !resp0_ready) r_hold0 <= sram_dout;
        if (r_inflight1 & !resp1_ready) r_hold1 <= sram_dout;
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed bench with an SRAM model and a transaction-level scoreboard.
// The scoreboard predicts grants, SRAM commands and response data every cycle.
module tb_sram_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
    logic [31:0] req_addr [2];
    logic [63:0] req_wdata [2];
    logic [7:0]  req_wstrb [2];
    logic [63:0] resp_rdata [2];
    logic [31:0] sram_addr;
    logic [63:0] sram_din, sram_dout;
    logic        sram_en;
    logic [7:0]  sram_we;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    sram_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req_valid[0]), .req0_ready(req_ready[0]), .req0_addr(req_addr[0]),
        .req0_wdata(req_wdata[0]), .req0_wstrb(req_wstrb[0]),
        .resp0_valid(resp_valid[0]), .resp0_ready(resp_ready[0]), .resp0_rdata(resp_rdata[0]),
        .req1_valid(req_valid[1]), .req1_ready(req_ready[1]), .req1_addr(req_addr[1]),
        .req1_wdata(req_wdata[1]), .req1_wstrb(req_wstrb[1]),
        .resp1_valid(resp_valid[1]), .resp1_ready(resp_ready[1]), .resp1_rdata(resp_rdata[1]),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_en(sram_en),
        .sram_we(sram_we), .sram_dout(sram_dout)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] init_word(input longint w);
        return (w < 16) ? 64'h0 : {32'(w) ^ 32'hA5A5A5A5, ~32'(w)};
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd, input logic [7:0] st);
        logic [63:0] r = old;
        for (int i = 0; i < 8; i++) if (st[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    // SRAM model: capture at the edge, data visible for the following cycle only
    logic [63:0] env_mem [longint];
    initial begin
        logic        s_en;
        logic [31:0] s_addr;
        logic [63:0] s_din, cur;
        logic [7:0]  s_we;
        longint      w;
        sram_dout = 64'hDEADBEEF0BADF00D;
        forever begin
            @(negedge clk);
            s_en = sram_en; s_addr = sram_addr; s_din = sram_din; s_we = sram_we;
            @(posedge clk);
            if (s_en) begin
                w   = longint'(s_addr >> 3);
                cur = merge(env_mem.exists(w) ? env_mem[w] : init_word(w), s_din, s_we);
                if (s_we != 0) env_mem[w] = cur;
                sram_dout <= cur;
            end else sram_dout <= 64'hDEADBEEF0BADF00D;
        end
    end

    // Scoreboard: each port has at most one outstanding response, served round-robin
    logic [63:0] mdl_mem [longint];
    initial begin
        logic [1:0]  m_busy = 2'b00, elig, cand;
        logic [63:0] m_data [2];
        logic        m_last = 1'b1;
        logic [63:0] cur;
        longint      w;
        int          win;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_req_ready", 64'(req_ready), 0);
                chk("rst_resp_valid", 64'(resp_valid), 0);
                chk("rst_sram_en", 64'(sram_en), 0);
                chk("rst_sram_we", 64'(sram_we), 0);
                m_busy = 2'b00;
                m_last = 1'b1;
            end else begin
                for (int p = 0; p < 2; p++) begin
                    elig[p] = !m_busy[p] | resp_ready[p];
                    cand[p] = req_valid[p] & elig[p];
                end
                win = (cand == 2'b11) ? (m_last ? 0 : 1) : cand[0] ? 0 : cand[1] ? 1 : -1;
                for (int p = 0; p < 2; p++) begin
                    chk($sformatf("accept%0d", p), 64'(req_valid[p] & req_ready[p]), 64'(win == p));
                    if (!elig[p]) chk($sformatf("ready_inelig%0d", p), 64'(req_ready[p]), 0);
                    chk($sformatf("resp_valid%0d", p), 64'(resp_valid[p]), 64'(m_busy[p]));
                    if (m_busy[p]) chk($sformatf("resp_rdata%0d", p), resp_rdata[p], m_data[p]);
                end
                chk("one_ready", 64'(req_ready == 2'b11), 0);
                chk("sram_en", 64'(sram_en), 64'(win >= 0));
                if (win >= 0) begin
                    chk("sram_addr", 64'(sram_addr), 64'(req_addr[win]));
                    chk("sram_din", sram_din, req_wdata[win]);
                    chk("sram_we", 64'(sram_we), 64'(req_wstrb[win]));
                end else chk("sram_we_idle", 64'(sram_we), 0);
                for (int p = 0; p < 2; p++) if (m_busy[p] && resp_ready[p]) m_busy[p] = 1'b0;
                if (win >= 0) begin
                    w   = longint'(req_addr[win] >> 3);
                    cur = merge(mdl_mem.exists(w) ? mdl_mem[w] : init_word(w), req_wdata[win], req_wstrb[win]);
                    if (req_wstrb[win] != 0) mdl_mem[w] = cur;
                    m_busy[win] = 1'b1;
                    m_data[win] = cur;
                    m_last      = (win == 1);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] g;
        int         acc, rsp;
        rst = 1'b1; req_valid = 2'b00; resp_ready = 2'b11;
        for (int p = 0; p < 2; p++) begin
            req_addr[p] = 0; req_wdata[p] = 0; req_wstrb[p] = 0;
        end
        repeat (2) cyc();
        @(negedge clk);
        chk("lit_rst_ready", 64'(req_ready), 0);
        chk("lit_rst_en", 64'(sram_en), 0);
        // both ports read continuously: grants alternate starting with port 0
        cyc();
        rst = 1'b0; req_valid = 2'b11; req_addr[0] = 32'h100; req_addr[1] = 32'h208;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            g[i] = req_ready[1];
            cyc();
        end
        chk("lit_rr_grants", 64'(g[3:0]), 64'b1010);
        req_valid = 2'b00;
        cyc(); cyc();
        // partial write then read-back of the same word
        req_addr[0] = 32'h40; req_wdata[0] = 64'h1122334455667788; req_wstrb[0] = 8'h0F; req_valid = 2'b01;
        @(negedge clk);
        chk("lit_wr_accept", 64'(req_ready[0]), 1);
        cyc();
        req_wstrb[0] = 8'h00;
        @(negedge clk);
        chk("lit_wr_resp", resp_rdata[0], 64'h0000000055667788);
        chk("lit_rd_accept", 64'(req_ready[0]), 1);
        cyc();
        req_valid = 2'b00;
        @(negedge clk);
        chk("lit_rd_resp_valid", 64'(resp_valid[0]), 1);
        chk("lit_rd_resp", resp_rdata[0], 64'h0000000055667788);
        cyc();
        // port 1 response stalled for three cycles while port 0 keeps streaming
        req_valid = 2'b11; req_addr[0] = 32'h400; req_addr[1] = 32'h300; resp_ready = 2'b01;
        @(negedge clk);
        chk("lit_hold_accept1", 64'(req_ready[1]), 1);
        cyc();
        req_addr[1] = 32'h308;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lit_hold_valid", 64'(resp_valid[1]), 1);
            chk("lit_hold_data", resp_rdata[1], init_word(96));
            chk("lit_hold_ready1", 64'(req_ready[1]), 0);
            chk("lit_hold_port0", 64'(req_ready[0]), 1);
            cyc();
        end
        resp_ready = 2'b11;
        @(negedge clk);
        chk("lit_regrant1", 64'(req_ready[1]), 1);
        chk("lit_release_data", resp_rdata[1], init_word(96));
        cyc();
        req_valid = 2'b00;
        cyc(); cyc();
        // lone port 1 sustains one access per cycle
        req_valid = 2'b10; acc = 0; rsp = 0;
        for (int i = 0; i < 4; i++) begin
            req_addr[1] = 32'h500 + 32'(8 * i);
            @(negedge clk);
            acc += int'(req_ready[1]);
            rsp += int'(resp_valid[1]);
            cyc();
        end
        req_valid = 2'b00;
        @(negedge clk);
        rsp += int'(resp_valid[1]);
        chk("lit_burst_accepts", 64'(acc), 4);
        chk("lit_burst_resps", 64'(rsp), 4);
        cyc();
        // reset right after an accepted write: response dropped, write kept, port 0 wins next tie
        req_valid = 2'b01; req_addr[0] = 32'h600; req_wdata[0] = 64'hCAFEF00D12345678; req_wstrb[0] = 8'hFF;
        @(negedge clk);
        chk("lit_pre_rst_accept", 64'(req_ready[0]), 1);
        cyc();
        rst = 1'b1; req_valid = 2'b00;
        @(negedge clk);
        chk("lit_rst_no_resp", 64'(resp_valid), 0);
        cyc();
        rst = 1'b0; req_valid = 2'b11; req_wstrb[0] = 8'h00; req_addr[1] = 32'h608;
        @(negedge clk);
        chk("lit_post_rst_tie", 64'(req_ready), 64'b01);
        chk("lit_post_rst_resp", 64'(resp_valid), 0);
        cyc();
        @(negedge clk);
        chk("lit_rst_write_kept", resp_rdata[0], 64'hCAFEF00D12345678);
        cyc();
        req_valid = 2'b00;
        repeat (3) cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
